// File: rtl/bus_mux_pkg.sv
// Shared types and constants for the bus read-response multiplexer.
// Response words, enable levels and the FSM state encoding live here.
package bus_mux_pkg;

    localparam int BUS_DATA = 32;

    localparam logic                EN            = 1'b1;
    localparam logic                DIS_EN        = 1'b0;
    localparam logic [BUS_DATA-1:0] ZERO_WORD     = {BUS_DATA{1'b0}};
    localparam logic [BUS_DATA-1:0] RESP_ERR_DATA = ZERO_WORD;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mux_state_t;

    // Watchdog counter width; a disabled watchdog still needs a 1-bit vector.
    function automatic int cnt_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/prio_enc_lsb.sv
// Lowest-set-bit priority encoder: bit 0 has the highest priority.
// Reusable by any arbiter that needs a fixed-priority grant index.
module prio_enc_lsb #(
    parameter  int W     = 5,
    localparam int IDX_W = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]     req_i,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx = {IDX_W{1'b0}};
        for (int i = W - 1; i >= 0; i--) begin
            idx = req_i[i] ? IDX_W'(i) : idx;
        end
        valid = |req_i;
    end

endmodule

// File: rtl/bus_slave_resp_mux_n.sv
// Registered read-response mux: locks onto the lowest enabled slave per request,
// returns its data with a one-cycle ready pulse, and error-terminates misses and timeouts.
module bus_slave_resp_mux_n
    import bus_mux_pkg::*;
#(
    parameter int N_SLAVE  = 5,
    parameter int DATA_W   = BUS_DATA,
    parameter int TIMEOUT  = 255,
    parameter int ERRCNT_W = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_i,
    input  logic [N_SLAVE-1:0]             c_en_i,
    input  logic [N_SLAVE-1:0][DATA_W-1:0] rd_data_i,
    input  logic [N_SLAVE-1:0]             ready_i,
    output logic [DATA_W-1:0]              rd_data_o,
    output logic                           ready_o,
    output logic                           err_o,
    output logic                           busy_o,
    output logic [ERRCNT_W-1:0]            err_cnt_o
);

    localparam int               IDX_W    = (N_SLAVE > 1) ? $clog2(N_SLAVE) : 1;
    localparam int               CNT_W    = cnt_width(TIMEOUT);
    localparam bit               WDOG_EN  = (TIMEOUT > 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    mux_state_t          state_q, state_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                ready_q, ready_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [IDX_W-1:0]    sel_q, sel_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [IDX_W-1:0]    enc_idx_s;
    logic                enc_valid_s;
    logic                enc_rdy_s;
    logic                sel_rdy_s;
    logic                tmo_s;

    prio_enc_lsb #(.W(N_SLAVE)) u_enc (
        .req_i (c_en_i),
        .idx   (enc_idx_s),
        .valid (enc_valid_s)
    );

    assign enc_rdy_s = ready_i[enc_idx_s];
    assign sel_rdy_s = ready_i[sel_q];
    assign tmo_s     = WDOG_EN && (cnt_q == CNT_LAST);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: only a request that cannot be answered at once enters WAIT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_i && enc_valid_s && !enc_rdy_s) begin
                    state_d = WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (sel_rdy_s || tmo_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Response, selection and watchdog next values; inputs are ignored while locked.
    always_comb begin
        rd_data_d = rd_data_q;
        ready_d   = DIS_EN;
        err_d     = DIS_EN;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_i && enc_valid_s) begin
                    if (enc_rdy_s) begin
                        rd_data_d = rd_data_i[enc_idx_s];
                        ready_d   = EN;
                    end else begin
                        sel_d = enc_idx_s;
                        cnt_d = {CNT_W{1'b0}};
                    end
                end else if (req_i) begin
                    rd_data_d = DATA_W'(RESP_ERR_DATA);
                    ready_d   = EN;
                    err_d     = EN;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            WAIT: begin
                if (sel_rdy_s) begin
                    rd_data_d = rd_data_i[sel_q];
                    ready_d   = EN;
                end else if (tmo_s) begin
                    rd_data_d = DATA_W'(RESP_ERR_DATA);
                    ready_d   = EN;
                    err_d     = EN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                ready_d = DIS_EN;
            end
        endcase
        busy_d = (state_d == WAIT);
        if (err_d && (err_cnt_q != {ERRCNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERRCNT_W'(1);
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Output and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= DATA_W'(ZERO_WORD);
            ready_q   <= DIS_EN;
            err_q     <= DIS_EN;
            busy_q    <= DIS_EN;
            err_cnt_q <= {ERRCNT_W{1'b0}};
            sel_q     <= {IDX_W{1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
        end else begin
            rd_data_q <= rd_data_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            err_cnt_q <= err_cnt_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
        end
    end

    assign rd_data_o = rd_data_q;
    assign ready_o   = ready_q;
    assign err_o     = err_q;
    assign busy_o    = busy_q;
    assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_bus_slave_resp_mux_n.sv
// Scoreboard bench for bus_slave_resp_mux_n with a 4-cycle watchdog: the driver
// queues expected responses with their due cycle, the monitor checks every cycle.
module tb_bus_slave_resp_mux_n;

    localparam int N  = 5;
    localparam int DW = 32;
    localparam int TO = 4;
    localparam int EW = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               req = 1'b0;
    logic [N-1:0]       c_en = '0;
    logic [N-1:0]       rdy = '0;
    logic [N-1:0][DW-1:0] rdata = '0;
    logic [DW-1:0]      rd_data_o;
    logic               ready_o;
    logic               err_o;
    logic               busy_o;
    logic [EW-1:0]      err_cnt_o;

    bus_slave_resp_mux_n #(
        .N_SLAVE(N), .DATA_W(DW), .TIMEOUT(TO), .ERRCNT_W(EW)
    ) dut (
        .clk(clk), .rst(rst), .req_i(req), .c_en_i(c_en),
        .rd_data_i(rdata), .ready_i(rdy),
        .rd_data_o(rd_data_o), .ready_o(ready_o), .err_o(err_o),
        .busy_o(busy_o), .err_cnt_o(err_cnt_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        logic [EW-1:0] cnt;
        int            due;
    } exp_t;

    exp_t sb[$];
    exp_t mx;
    int   checks   = 0;
    int   failures = 0;
    int   exp_cnt  = 0;
    logic exp_rdy;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in the cycle the request is driven; lat = cycles until ready_o.
    task automatic push(input logic [DW-1:0] d, input logic e, input int lat);
        exp_t x;
        if (e) exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
        x.data = d;
        x.err  = e;
        x.cnt  = EW'(exp_cnt);
        x.due  = cyc + lat;
        sb.push_back(x);
    endtask

    // Monitor: ready_o must appear exactly when the head entry is due.
    initial begin
        forever begin
            @(negedge clk);
            exp_rdy = (sb.size() > 0) && (sb[0].due == cyc);
            chk("ready_timing", ready_o, exp_rdy);
            if (exp_rdy) begin
                mx = sb.pop_front();
                if (ready_o) begin
                    chk("rsp_data", rd_data_o, mx.data);
                    chk("rsp_err", err_o, mx.err);
                    chk("rsp_errcnt", err_cnt_o, mx.cnt);
                end
            end else if (!ready_o) begin
                chk("err_without_ready", err_o, 1'b0);
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", rd_data_o, 32'h0);
        chk("rst_ready", ready_o, 1'b0);
        chk("rst_err", err_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_errcnt", err_cnt_o, 8'h00);
        rst = 1'b0;
        tick();

        // Immediate response; slave 2 ready too but lower priority than slave 1.
        c_en = 5'b00110; rdy = 5'b00110;
        rdata[1] = 32'hDEAD_BEEF; rdata[2] = 32'hAAAA_5555;
        req = 1'b1; push(32'hDEAD_BEEF, 1'b0, 1);
        tick();
        req = 1'b0; c_en = '0; rdy = '0;
        chk("t1_busy", busy_o, 1'b0);
        tick();

        // Slave 3 answers 4 cycles later; decoder noise and a stray req during WAIT.
        c_en = 5'b01000; rdy = '0; rdata[3] = 32'hCAFE_0000;
        req = 1'b1; push(32'h1234_5678, 1'b0, 5);
        for (int j = 1; j <= 4; j++) begin
            tick();
            req = 1'b0;
            c_en = 5'b00001; rdy = 5'b00001; rdata[0] = 32'hFFFF_0000;
            if (j == 2) req = 1'b1;
            if (j == 4) begin
                rdy = 5'b01000; rdata[3] = 32'h1234_5678; c_en = 5'b10000;
            end
            chk("t2_busy", busy_o, 1'b1);
        end
        tick();
        rdy = '0; c_en = '0;
        chk("t2_busy_end", busy_o, 1'b0);
        tick();

        // Decode miss.
        c_en = '0; rdata[0] = 32'h7777_7777;
        req = 1'b1; push(32'h0, 1'b1, 1);
        tick();
        req = 1'b0;
        tick();

        // Silent slave: watchdog fires TIMEOUT+1 cycles after the request.
        c_en = 5'b00100; rdy = '0; rdata[2] = 32'h5555_AAAA;
        req = 1'b1; push(32'h0, 1'b1, 5);
        tick();
        req = 1'b0;
        repeat (3) tick();
        chk("t4_busy", busy_o, 1'b1);
        tick();
        chk("t4_busy_end", busy_o, 1'b0);
        tick();

        // Back-to-back: second request in the cycle ready_o is high.
        c_en = 5'b00001; rdy = 5'b00001; rdata[0] = 32'h0000_0001;
        req = 1'b1; push(32'h0000_0001, 1'b0, 1);
        tick();
        c_en = 5'b00011; rdata[0] = 32'h0000_0002;
        req = 1'b1; push(32'h0000_0002, 1'b0, 1);
        tick();
        req = 1'b0; rdy = '0; c_en = '0;
        tick();

        // Reset two cycles into WAIT aborts the transaction silently.
        c_en = 5'b10000; rdy = '0;
        req = 1'b1;
        tick();
        req = 1'b0;
        tick();
        rst = 1'b1;
        exp_cnt = 0;
        #1;
        chk("abort_busy", busy_o, 1'b0);
        chk("abort_ready", ready_o, 1'b0);
        chk("abort_errcnt", err_cnt_o, 8'h00);
        tick();
        rst = 1'b0;
        rdy = 5'b10000; rdata[4] = 32'hBBBB_BBBB;
        repeat (4) tick();
        rdy = '0;
        tick();
        c_en = 5'b10000; rdy = 5'b10000; rdata[4] = 32'h0BAD_F00D;
        req = 1'b1; push(32'h0BAD_F00D, 1'b0, 1);
        tick();
        req = 1'b0; rdy = '0;
        tick();

        // 300 timeouts saturate the 8-bit error counter.
        c_en = 5'b00001; rdy = '0;
        for (int i = 0; i < 300; i++) begin
            req = 1'b1; push(32'h0, 1'b1, 5);
            tick();
            req = 1'b0;
            repeat (5) tick();
        end
        chk("errcnt_saturated", err_cnt_o, 8'hFF);

        for (int k = 0; k < 20 && sb.size() > 0; k++) tick();
        chk("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
